// File: rtl/fetch_ctrl.sv
// fetch_ctrl: picks the PC source each cycle and sequences flush / fetch-valid for the front end.
// Defining FETCH_PERF_CNT_EN adds saturating stall, flush and interrupt counters.
module fetch_ctrl #(
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] IRQ_VEC      = ADDR_W'(16'h0010),
  parameter int                FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic [ADDR_W-1:0] pc_seq,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              irq_req,
  input  logic              irq_ret,
  input  logic              halt_req,
  input  logic              resume,
  output logic              pc_en,
  output logic [ADDR_W-1:0] pc_addr,
  output logic              flush,
  output logic              fetch_valid,
  output logic              irq_ack,
  output logic [ADDR_W-1:0] epc,
  output logic              in_irq,
  output logic [1:0]        state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cyc,
  output logic [31:0]       flush_cyc,
  output logic [15:0]       irq_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [2:0] FLUSH_LOAD     = 3'(FLUSH_CYCLES - 1);
  localparam state_t     REDIRECT_STATE = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              in_irq_q, in_irq_d;
  logic              redirect;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      cnt_q    <= 3'd0;
      epc_q    <= '0;
      in_irq_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      epc_q    <= epc_d;
      in_irq_q <= in_irq_d;
    end
  end

  // Redirects are checked first; only a branch may interrupt FLUSH, and irq_ret only acts from RUN/STALL.
  always_comb begin
    pc_en       = 1'b0;
    pc_addr     = pc_seq;
    flush       = 1'b0;
    fetch_valid = 1'b0;
    irq_ack     = 1'b0;
    redirect    = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    epc_d       = epc_q;
    in_irq_d    = in_irq_q;
    if (!reset) begin
      if (br_taken) begin
        redirect = 1'b1;
        pc_addr  = br_target;
      end else if (irq_ret && in_irq_q && (state_q == RUN || state_q == STALL)) begin
        redirect = 1'b1;
        pc_addr  = epc_q;
        in_irq_d = 1'b0;
      end else if (irq_req && !in_irq_q && state_q != FLUSH) begin
        redirect = 1'b1;
        pc_addr  = IRQ_VEC;
        irq_ack  = 1'b1;
        epc_d    = pc_cur;
        in_irq_d = 1'b1;
      end else begin
        case (state_q)
          RUN, STALL: begin
            if (halt_req) begin
              state_d = HALT;
            end else if (stall) begin
              state_d = STALL;
            end else begin
              pc_en       = 1'b1;
              fetch_valid = 1'b1;
              state_d     = RUN;
            end
          end
          FLUSH: begin
            flush = 1'b1;
            if (!stall) begin
              pc_en = 1'b1;
              if (cnt_q <= 3'd1) begin
                cnt_d   = 3'd0;
                state_d = RUN;
              end else begin
                cnt_d = cnt_q - 3'd1;
              end
            end
          end
          HALT: begin
            if (resume) state_d = RUN;
          end
          default: state_d = RUN;
        endcase
      end
      if (redirect) begin
        pc_en   = 1'b1;
        flush   = 1'b1;
        cnt_d   = FLUSH_LOAD;
        state_d = REDIRECT_STATE;
      end
    end
  end

  assign epc    = epc_q;
  assign in_irq = in_irq_q;
  assign state  = state_q;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cyc <= '0;
      flush_cyc <= '0;
      irq_cnt   <= '0;
    end else begin
      if (stall && !pc_en && stall_cyc != '1) stall_cyc <= stall_cyc + 32'd1;
      if (flush && flush_cyc != '1)           flush_cyc <= flush_cyc + 32'd1;
      if (irq_ack && irq_cnt != '1)           irq_cnt   <= irq_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vector table, reset corner cases and random traffic checked against a
// cycle-level behavioural model of the fetch controller.
module tb_fetch_ctrl;

  localparam int          FLUSH_CYCLES = 2;
  localparam logic [15:0] IRQ_VEC      = 16'h0010;

  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_STALL = 6'b100000;
  localparam logic [5:0] C_BR    = 6'b010000;
  localparam logic [5:0] C_IRQ   = 6'b001000;
  localparam logic [5:0] C_RET   = 6'b000100;
  localparam logic [5:0] C_HALT  = 6'b000010;
  localparam logic [5:0] C_RES   = 6'b000001;
  localparam logic [2:0] FL = 3'b100, FV = 3'b010, ACK = 3'b001;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc_cur, pc_seq, br_target;
  logic        stall, br_taken, irq_req, irq_ret, halt_req, resume;
  logic        pc_en, flush, fetch_valid, irq_ack, in_irq;
  logic [15:0] pc_addr, epc;
  logic [1:0]  state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cyc, flush_cyc;
  logic [15:0] irq_cnt;
`endif

  fetch_ctrl #(.ADDR_W(16), .IRQ_VEC(IRQ_VEC), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .reset(reset), .pc_cur(pc_cur), .pc_seq(pc_seq), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .irq_req(irq_req), .irq_ret(irq_ret),
    .halt_req(halt_req), .resume(resume), .pc_en(pc_en), .pc_addr(pc_addr), .flush(flush),
    .fetch_valid(fetch_valid), .irq_ack(irq_ack), .epc(epc), .in_irq(in_irq), .state(state)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cyc(stall_cyc), .flush_cyc(flush_cyc), .irq_cnt(irq_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  ctl;
    logic [15:0] target;
    logic        pc_en;
    logic [15:0] addr;
    logic [2:0]  ffa;
    logic [1:0]  st;
    logic        in_irq;
    logic [15:0] epc;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  // Behavioural model: remaining squash cycles, halted/stalled flags, handler bookkeeping.
  bit          m_halted, m_stalled, m_in_irq;
  int          m_flush_left;
  logic [15:0] m_epc, m_pc;
  int          m_acks;
  bit          n_halted, n_stalled, n_in_irq;
  int          n_flush_left;
  logic [15:0] n_epc;
  logic        e_pc_en, e_flush, e_fv, e_ack;
  logic [15:0] e_addr;
  logic [1:0]  e_state;

  task automatic addVec(input logic [5:0] ctl, input logic [15:0] tgt, input logic en,
                        input logic [15:0] addr, input logic [2:0] ffa, input logic [1:0] st,
                        input logic ii, input logic [15:0] ep);
    vec_t v;
    v.ctl = ctl; v.target = tgt; v.pc_en = en; v.addr = addr;
    v.ffa = ffa; v.st = st; v.in_irq = ii; v.epc = ep;
    vq.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_halted = 0; m_stalled = 0; m_in_irq = 0; m_flush_left = 0;
    m_epc = 16'h0; m_pc = 16'h0; m_acks = 0;
    pc_cur = m_pc; pc_seq = m_pc + 16'd2;
  endtask

  task automatic modelEval();
    bit in_fl, redir;
    in_fl = (m_flush_left > 0);
    redir = 0;
    e_pc_en = 0; e_addr = pc_seq; e_flush = 0; e_fv = 0; e_ack = 0;
    n_halted = m_halted; n_stalled = m_stalled; n_in_irq = m_in_irq;
    n_flush_left = m_flush_left; n_epc = m_epc;
    e_state = m_halted ? 2'd3 : in_fl ? 2'd2 : m_stalled ? 2'd1 : 2'd0;
    if (br_taken) begin
      redir = 1; e_addr = br_target;
    end else if (irq_ret && m_in_irq && !in_fl && !m_halted) begin
      redir = 1; e_addr = m_epc; n_in_irq = 0;
    end else if (irq_req && !m_in_irq && !in_fl) begin
      redir = 1; e_addr = IRQ_VEC; e_ack = 1; n_epc = pc_cur; n_in_irq = 1;
    end else if (m_halted) begin
      if (resume) n_halted = 0;
    end else if (in_fl) begin
      e_flush = 1;
      if (!stall) begin
        e_pc_en = 1;
        n_flush_left = m_flush_left - 1;
      end
    end else if (halt_req) begin
      n_halted = 1; n_stalled = 0;
    end else if (stall) begin
      n_stalled = 1;
    end else begin
      e_pc_en = 1; e_fv = 1; n_stalled = 0;
    end
    if (redir) begin
      e_pc_en = 1; e_flush = 1;
      n_flush_left = FLUSH_CYCLES - 1;
      n_halted = 0; n_stalled = 0;
    end
  endtask

  task automatic applyStimulus(input logic [5:0] ctl, input logic [15:0] tgt);
    {stall, br_taken, irq_req, irq_ret, halt_req, resume} = ctl;
    br_target = tgt;
    @(negedge clk);
    modelEval();
  endtask

  task automatic compareModel(input string tag);
    checkOutput({tag, ".pc_en"}, 32'(pc_en), 32'(e_pc_en));
    if (e_pc_en) checkOutput({tag, ".pc_addr"}, 32'(pc_addr), 32'(e_addr));
    checkOutput({tag, ".flush"}, 32'(flush), 32'(e_flush));
    checkOutput({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(e_fv));
    checkOutput({tag, ".irq_ack"}, 32'(irq_ack), 32'(e_ack));
    checkOutput({tag, ".state"}, 32'(state), 32'(e_state));
    checkOutput({tag, ".in_irq"}, 32'(in_irq), 32'(m_in_irq));
    checkOutput({tag, ".epc"}, 32'(epc), 32'(m_epc));
  endtask

  task automatic advance();
    @(posedge clk);
    m_halted = n_halted; m_stalled = n_stalled; m_in_irq = n_in_irq;
    m_flush_left = n_flush_left; m_epc = n_epc;
    if (e_ack) m_acks++;
    if (e_pc_en) m_pc = e_addr;
    #1;
    pc_cur = m_pc; pc_seq = m_pc + 16'd2;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".state"}, 32'(state), 32'd0);
    checkOutput({tag, ".pc_en"}, 32'(pc_en), 32'd0);
    checkOutput({tag, ".flush"}, 32'(flush), 32'd0);
    checkOutput({tag, ".fetch_valid"}, 32'(fetch_valid), 32'd0);
    checkOutput({tag, ".irq_ack"}, 32'(irq_ack), 32'd0);
    checkOutput({tag, ".in_irq"}, 32'(in_irq), 32'd0);
    checkOutput({tag, ".epc"}, 32'(epc), 32'd0);
    checkOutput({tag, ".pc_addr"}, 32'(pc_addr), 32'(pc_seq));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    {stall, br_taken, irq_req, irq_ret, halt_req, resume} = C_NONE;
    br_target = 16'h0;
    modelReset();

    // Reset release, branch, interrupt entry/return, branch+irq, stalled flush, halt/resume
    addVec(C_NONE, 16'h0, 1, 16'h0002, FV, 0, 0, 16'h0000);
    addVec(C_NONE, 16'h0, 1, 16'h0004, FV, 0, 0, 16'h0000);
    addVec(C_NONE, 16'h0, 1, 16'h0006, FV, 0, 0, 16'h0000);
    addVec(C_NONE, 16'h0, 1, 16'h0008, FV, 0, 0, 16'h0000);
    addVec(C_BR, 16'h0040, 1, 16'h0040, FL, 0, 0, 16'h0000);
    addVec(C_NONE, 16'h0, 1, 16'h0042, FL, 2, 0, 16'h0000);
    addVec(C_NONE, 16'h0, 1, 16'h0044, FV, 0, 0, 16'h0000);
    addVec(C_BR, 16'h001C, 1, 16'h001C, FL, 0, 0, 16'h0000);
    addVec(C_NONE, 16'h0, 1, 16'h001E, FL, 2, 0, 16'h0000);
    addVec(C_NONE, 16'h0, 1, 16'h0020, FV, 0, 0, 16'h0000);
    addVec(C_IRQ, 16'h0, 1, 16'h0010, FL | ACK, 0, 0, 16'h0000);
    addVec(C_IRQ, 16'h0, 1, 16'h0012, FL, 2, 1, 16'h0020);
    addVec(C_IRQ, 16'h0, 1, 16'h0014, FV, 0, 1, 16'h0020);
    addVec(C_RET, 16'h0, 1, 16'h0020, FL, 0, 1, 16'h0020);
    addVec(C_NONE, 16'h0, 1, 16'h0022, FL, 2, 0, 16'h0020);
    addVec(C_NONE, 16'h0, 1, 16'h0024, FV, 0, 0, 16'h0020);
    addVec(C_BR | C_IRQ, 16'h0080, 1, 16'h0080, FL, 0, 0, 16'h0020);
    addVec(C_IRQ, 16'h0, 1, 16'h0082, FL, 2, 0, 16'h0020);
    addVec(C_IRQ, 16'h0, 1, 16'h0010, FL | ACK, 0, 0, 16'h0020);
    addVec(C_NONE, 16'h0, 1, 16'h0012, FL, 2, 1, 16'h0082);
    addVec(C_RET, 16'h0, 1, 16'h0082, FL, 0, 1, 16'h0082);
    addVec(C_STALL, 16'h0, 0, 16'h0000, FL, 2, 0, 16'h0082);
    addVec(C_STALL, 16'h0, 0, 16'h0000, FL, 2, 0, 16'h0082);
    addVec(C_STALL, 16'h0, 0, 16'h0000, FL, 2, 0, 16'h0082);
    addVec(C_NONE, 16'h0, 1, 16'h0084, FL, 2, 0, 16'h0082);
    addVec(C_NONE, 16'h0, 1, 16'h0086, FV, 0, 0, 16'h0082);
    addVec(C_HALT, 16'h0, 0, 16'h0000, 3'b000, 0, 0, 16'h0082);
    addVec(C_NONE, 16'h0, 0, 16'h0000, 3'b000, 3, 0, 16'h0082);
    addVec(C_NONE, 16'h0, 0, 16'h0000, 3'b000, 3, 0, 16'h0082);
    addVec(C_IRQ, 16'h0, 1, 16'h0010, FL | ACK, 3, 0, 16'h0082);
    addVec(C_NONE, 16'h0, 1, 16'h0012, FL, 2, 1, 16'h0086);
    addVec(C_RET, 16'h0, 1, 16'h0086, FL, 0, 1, 16'h0086);
    addVec(C_NONE, 16'h0, 1, 16'h0088, FL, 2, 0, 16'h0086);
    addVec(C_STALL, 16'h0, 0, 16'h0000, 3'b000, 0, 0, 16'h0086);
    addVec(C_STALL, 16'h0, 0, 16'h0000, 3'b000, 1, 0, 16'h0086);
    addVec(C_NONE, 16'h0, 1, 16'h008A, FV, 1, 0, 16'h0086);
    addVec(C_HALT, 16'h0, 0, 16'h0000, 3'b000, 0, 0, 16'h0086);
    addVec(C_RES, 16'h0, 0, 16'h0000, 3'b000, 3, 0, 16'h0086);
    addVec(C_NONE, 16'h0, 1, 16'h008C, FV, 0, 0, 16'h0086);

    #3;
    checkResetOutputs("reset_held");
    checkOutput("reset_held.pc_addr_const", 32'(pc_addr), 32'h0002);
    @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (vq[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      applyStimulus(vq[i].ctl, vq[i].target);
      checkOutput({tag, ".pc_en"}, 32'(pc_en), 32'(vq[i].pc_en));
      if (vq[i].pc_en) checkOutput({tag, ".pc_addr"}, 32'(pc_addr), 32'(vq[i].addr));
      checkOutput({tag, ".flags"}, 32'({flush, fetch_valid, irq_ack}), 32'(vq[i].ffa));
      checkOutput({tag, ".state"}, 32'(state), 32'(vq[i].st));
      checkOutput({tag, ".in_irq"}, 32'(in_irq), 32'(vq[i].in_irq));
      checkOutput({tag, ".epc"}, 32'(epc), 32'(vq[i].epc));
      compareModel({tag, ".model"});
      advance();
    end

    // Reset asserted while halted returns to RUN without waiting for a clock edge
    applyStimulus(C_HALT, 16'h0);
    compareModel("halt_enter");
    advance();
    applyStimulus(C_NONE, 16'h0);
    checkOutput("halted.state", 32'(state), 32'd3);
    #2 reset = 1'b1;
    #1 checkResetOutputs("reset_in_halt");
    @(posedge clk);
    #1 reset = 1'b0;
    modelReset();

    // Reset during the squash window after an interrupt clears the handler state
    applyStimulus(C_NONE, 16'h0); compareModel("pre_irq0"); advance();
    applyStimulus(C_NONE, 16'h0); compareModel("pre_irq1"); advance();
    applyStimulus(C_IRQ, 16'h0);  compareModel("irq_take"); advance();
    applyStimulus(C_NONE, 16'h0);
    checkOutput("in_flush.state", 32'(state), 32'd2);
    checkOutput("in_flush.epc", 32'(epc), 32'h0004);
    #2 reset = 1'b1;
    #1 checkResetOutputs("reset_in_flush");
    @(posedge clk);
    #1 reset = 1'b0;
    modelReset();

    for (int i = 0; i < 600; i++) begin
      logic [5:0] ctl;
      ctl = {($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 11) == 0), ($urandom_range(0, 3) == 0)};
      applyStimulus(ctl, 16'($urandom) & 16'hFFFE);
      compareModel($sformatf("rand%0d", i));
      advance();
    end

`ifdef FETCH_PERF_CNT_EN
    checkOutput("perf.irq_cnt", 32'(irq_cnt), 32'(m_acks));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
